// File: rtl/next_pc_predictor_if.sv
// Fetch/resolve-side signal bundle for the next-PC predictor.
// The master side is the core (fetch + resolve). The slave side is the predictor.
interface next_pc_predictor_if #(
   parameter int DBITS = 16
);
   logic [DBITS-1:0] lookup_pc;
   logic [DBITS-1:0] pred_pc;
   logic             pred_hit;
   logic             pred_taken;
   logic             upd_en;
   logic [DBITS-1:0] upd_pc;
   logic             upd_taken;
   logic [DBITS-1:0] upd_target;
   logic             flush_all;
   logic             ready;

   modport master (
      output lookup_pc, upd_en, upd_pc, upd_taken, upd_target, flush_all,
      input  pred_pc, pred_hit, pred_taken, ready
   );

   modport slave (
      input  lookup_pc, upd_en, upd_pc, upd_taken, upd_target, flush_all,
      output pred_pc, pred_hit, pred_taken, ready
   );
endinterface

// File: rtl/next_pc_predictor.sv
// Tagged branch-target / next-PC predictor with 2-bit taken counters.
// Lookups are combinational from the table. Updates are written at the clock edge.
// After reset or a flush, a sweep clears every valid bit before RUN is entered.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_INIT | clearing valid[sweep] each clock; lookups miss, updates ignored
//   ST_RUN  | normal prediction and update; FLUSH_ALL returns to ST_INIT
module next_pc_predictor #(
   parameter int DBITS      = 16,
   parameter int IBITS      = 8,
   parameter int TBITS      = 4,
   parameter int ALIGN      = 1,
   parameter int INST_BYTES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   next_pc_predictor_if.slave bus
);
   localparam int DEPTH = 1 << IBITS;
   localparam int EBITS = TBITS + DBITS + 2;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t             state;
   logic [IBITS-1:0]   sweep;
   logic               ready_q;

   // Entry layout: {tag, target, ctr}. Valid bits live in flops so the sweep
   // and the RAM write port never compete.
   logic [EBITS-1:0]   mem [DEPTH];
   logic [DEPTH-1:0]   valid;

   logic [IBITS-1:0]   lk_idx;
   logic [TBITS-1:0]   lk_tag;
   logic [EBITS-1:0]   lk_ent;
   logic               lk_hit;
   logic               lk_taken;

   logic [IBITS-1:0]   up_idx;
   logic [TBITS-1:0]   up_tag;
   logic [EBITS-1:0]   up_ent;
   logic               up_hit;
   logic               wr_en;
   logic [1:0]         wr_ctr;
   logic [DBITS-1:0]   wr_target;

   // Only the index and tag fields of the update PC select an entry.
   logic               unused_upd_pc;
   assign unused_upd_pc = ^bus.upd_pc;

   // Lookup path: reads pre-update contents, so a same-cycle update shows next cycle.
   always_comb begin
      lk_idx   = bus.lookup_pc[ALIGN+IBITS-1:ALIGN];
      lk_tag   = bus.lookup_pc[ALIGN+IBITS+TBITS-1:ALIGN+IBITS];
      lk_ent   = mem[lk_idx];
      lk_hit   = (state == ST_RUN) && valid[lk_idx] &&
                 (lk_ent[EBITS-1 -: TBITS] == lk_tag);
      lk_taken = lk_hit && lk_ent[1];
   end

   assign bus.pred_hit   = lk_hit;
   assign bus.pred_taken = lk_taken;
   assign bus.pred_pc    = lk_taken ? lk_ent[DBITS+1:2]
                                    : bus.lookup_pc + DBITS'(INST_BYTES);
   assign bus.ready      = ready_q;

   // Update decode: train a matching entry, allocate on a taken miss.
   always_comb begin
      up_idx    = bus.upd_pc[ALIGN+IBITS-1:ALIGN];
      up_tag    = bus.upd_pc[ALIGN+IBITS+TBITS-1:ALIGN+IBITS];
      up_ent    = mem[up_idx];
      up_hit    = valid[up_idx] && (up_ent[EBITS-1 -: TBITS] == up_tag);
      wr_en     = (state == ST_RUN) && !bus.flush_all && bus.upd_en &&
                  (up_hit || bus.upd_taken);
      wr_ctr    = 2'd2;
      wr_target = bus.upd_target;
      if (up_hit) begin
         if (bus.upd_taken) begin
            wr_ctr = (up_ent[1:0] == 2'd3) ? 2'd3 : up_ent[1:0] + 2'd1;
         end else begin
            wr_ctr    = (up_ent[1:0] == 2'd0) ? 2'd0 : up_ent[1:0] - 2'd1;
            wr_target = up_ent[DBITS+1:2];
         end
      end
   end

   // Table RAM: single write port, no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[up_idx] <= {up_tag, wr_target, wr_ctr};
      end
   end

   // Valid flops: cleared one per clock by the sweep, set on a table write.
   always_ff @(posedge clk) begin
      if (state == ST_INIT) begin
         valid[sweep] <= 1'b0;
      end else if (wr_en) begin
         valid[up_idx] <= 1'b1;
      end
   end

   // Sequencing FSM: sweep after reset/flush, then RUN with READY asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_INIT;
         sweep   <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               sweep <= sweep + IBITS'(1);
               if (sweep == IBITS'(DEPTH - 1)) begin
                  state   <= ST_RUN;
                  ready_q <= 1'b1;
               end
            end
            ST_RUN: begin
               if (bus.flush_all) begin
                  state   <= ST_INIT;
                  sweep   <= '0;
                  ready_q <= 1'b0;
               end
            end
            default: begin
               state   <= ST_INIT;
               sweep   <= '0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_next_pc_predictor.sv
module tb_next_pc_predictor;
   logic clk;
   logic rst_n;

   next_pc_predictor_if #(.DBITS(16)) bus ();

   next_pc_predictor dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] pc;
      logic        hit;
      logic        taken;
      logic        rdy;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compares the DUT outputs against the oldest expectation every falling edge.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check_val({e.name, ".pred_pc"},    32'(bus.pred_pc),    32'(e.pc));
         check_val({e.name, ".pred_hit"},   32'(bus.pred_hit),   32'(e.hit));
         check_val({e.name, ".pred_taken"}, 32'(bus.pred_taken), 32'(e.taken));
         check_val({e.name, ".ready"},      32'(bus.ready),      32'(e.rdy));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a lookup, queue its expected response, advance one cycle.
   task automatic look(input string name, input logic [15:0] pc, input logic [15:0] exp_pc,
                       input logic hit, input logic taken, input logic rdy);
      exp_t e;
      bus.lookup_pc = pc;
      e.name = name; e.pc = exp_pc; e.hit = hit; e.taken = taken; e.rdy = rdy;
      sb.push_back(e);
      tick();
   endtask

   task automatic upd(input logic [15:0] pc, input logic taken, input logic [15:0] tgt);
      bus.upd_en     = 1'b1;
      bus.upd_pc     = pc;
      bus.upd_taken  = taken;
      bus.upd_target = tgt;
      tick();
      bus.upd_en     = 1'b0;
   endtask

   task automatic wait_ready(input string name, input int exp_n);
      int n;
      n = 0;
      while (bus.ready !== 1'b1 && n < 1000) begin
         tick();
         n++;
      end
      check_val(name, 32'(n), 32'(exp_n));
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.lookup_pc  = 16'h0200;
      bus.upd_en     = 1'b0;
      bus.upd_pc     = '0;
      bus.upd_taken  = 1'b0;
      bus.upd_target = '0;
      bus.flush_all  = 1'b0;
      tick();

      // Reset held: miss, sequential PC, not ready.
      look("rst_hold0", 16'h0200, 16'h0202, 1'b0, 1'b0, 1'b0);
      look("rst_hold1", 16'h0200, 16'h0202, 1'b0, 1'b0, 1'b0);

      // Release; an update strobe held during the sweep must be ignored.
      rst_n          = 1'b1;
      bus.upd_en     = 1'b1;
      bus.upd_pc     = 16'h0230;
      bus.upd_taken  = 1'b1;
      bus.upd_target = 16'h1234;
      begin
         exp_t e;
         e.name = "init_miss"; e.pc = 16'h0202; e.hit = 1'b0; e.taken = 1'b0; e.rdy = 1'b0;
         sb.push_back(e);
      end
      wait_ready("sweep_len_reset", 256);
      bus.upd_en = 1'b0;

      look("run_miss",       16'h0200, 16'h0202, 1'b0, 1'b0, 1'b1);
      look("init_upd_ign",   16'h0230, 16'h0232, 1'b0, 1'b0, 1'b1);

      // Allocate and hit (ctr=2).
      upd(16'h0210, 1'b1, 16'h0200);
      look("alloc_hit",      16'h0210, 16'h0200, 1'b1, 1'b1, 1'b1);

      // Hysteresis.
      upd(16'h0210, 1'b0, 16'h0000);                       // ctr 1
      look("hyst_nt1",       16'h0210, 16'h0212, 1'b1, 1'b0, 1'b1);
      upd(16'h0210, 1'b1, 16'h0200);                       // ctr 2
      upd(16'h0210, 1'b1, 16'h0200);                       // ctr 3
      upd(16'h0210, 1'b1, 16'h0200);                       // ctr 3 (sat)
      look("hyst_t3",        16'h0210, 16'h0200, 1'b1, 1'b1, 1'b1);
      upd(16'h0210, 1'b0, 16'h0000);                       // ctr 2
      look("hyst_sat_nt1",   16'h0210, 16'h0200, 1'b1, 1'b1, 1'b1);
      upd(16'h0210, 1'b0, 16'h0000);                       // ctr 1
      look("hyst_sat_nt2",   16'h0210, 16'h0212, 1'b1, 1'b0, 1'b1);
      upd(16'h0210, 1'b0, 16'h0000);                       // ctr 0
      upd(16'h0210, 1'b0, 16'h0000);                       // ctr 0 (sat)
      look("ctr0_valid",     16'h0210, 16'h0212, 1'b1, 1'b0, 1'b1);
      upd(16'h0210, 1'b1, 16'h0280);                       // ctr 1, target 0x0280
      look("ctr0_sat_t1",    16'h0210, 16'h0212, 1'b1, 1'b0, 1'b1);
      upd(16'h0210, 1'b1, 16'h0280);                       // ctr 2
      look("retarget",       16'h0210, 16'h0280, 1'b1, 1'b1, 1'b1);

      // Alias at idx 0x08: tag 2 vs tag 1.
      look("alias_miss",     16'h0410, 16'h0412, 1'b0, 1'b0, 1'b1);
      upd(16'h0410, 1'b0, 16'h0000);
      look("alias_nt_keep",  16'h0210, 16'h0280, 1'b1, 1'b1, 1'b1);
      upd(16'h0410, 1'b1, 16'h0300);
      look("alias_replace",  16'h0410, 16'h0300, 1'b1, 1'b1, 1'b1);
      look("alias_evicted",  16'h0210, 16'h0212, 1'b0, 1'b0, 1'b1);

      // Sequential wrap.
      look("wrap",           16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b1);

      // Same-cycle update and lookup.
      bus.upd_en     = 1'b1;
      bus.upd_pc     = 16'h0220;
      bus.upd_taken  = 1'b1;
      bus.upd_target = 16'h0400;
      look("same_cyc_old",   16'h0220, 16'h0222, 1'b0, 1'b0, 1'b1);
      bus.upd_en     = 1'b0;
      look("same_cyc_new",   16'h0220, 16'h0400, 1'b1, 1'b1, 1'b1);

      // Flush with a concurrent update: update dropped, table swept.
      bus.flush_all  = 1'b1;
      bus.upd_en     = 1'b1;
      bus.upd_pc     = 16'h0240;
      bus.upd_taken  = 1'b1;
      bus.upd_target = 16'h0500;
      look("flush_cycle",    16'h0410, 16'h0300, 1'b1, 1'b1, 1'b1);
      bus.flush_all  = 1'b0;
      bus.upd_en     = 1'b0;
      begin
         exp_t e;
         e.name = "flush_init"; e.pc = 16'h0412; e.hit = 1'b0; e.taken = 1'b0; e.rdy = 1'b0;
         sb.push_back(e);
      end
      wait_ready("sweep_len_flush", 256);
      look("post_flush_a",   16'h0410, 16'h0412, 1'b0, 1'b0, 1'b1);
      look("post_flush_b",   16'h0220, 16'h0222, 1'b0, 1'b0, 1'b1);
      look("flush_upd_drop", 16'h0240, 16'h0242, 1'b0, 1'b0, 1'b1);

      // Reset mid-sweep restarts it from zero.
      upd(16'h0250, 1'b1, 16'h0600);
      bus.flush_all = 1'b1;
      tick();
      bus.flush_all = 1'b0;
      repeat (100) tick();
      rst_n = 1'b0;
      look("mid_rst",        16'h0250, 16'h0252, 1'b0, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
      wait_ready("sweep_len_midrst", 256);
      look("post_midrst",    16'h0250, 16'h0252, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
